// File: rtl/fb_regfile.sv
// Two-read, one-write register file with RISC-V x0 semantics and write-through bypass.
// Register 0 is hardwired to zero; all contents clear asynchronously while reset is low.
module fb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_en;

  // Case-equality keeps an X on we from being treated as a write in simulation;
  // it reduces to a plain compare in synthesis.
  assign wr_en = (we === 1'b1) && (waddr != '0);

  // NOTE: every entry is cleared by the asynchronous reset, so this array maps to
  // flops rather than a RAM macro; contents must read zero without any clock.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // NOTE: outputs get a default before any branch so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (reset) begin
      if (raddr1 != '0) begin
        rdata1 = (wr_en && (raddr1 == waddr)) ? wdata : regs[raddr1];
      end
      if (raddr2 != '0) begin
        rdata2 = (wr_en && (raddr2 == waddr)) ? wdata : regs[raddr2];
      end
    end
  end

endmodule

// File: tb/tb_fb_regfile.sv
// Self-checking bench for fb_regfile: directed literal checks plus randomized
// traffic compared every cycle against an array-based reference model.
module tb_fb_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  raddr1, raddr2, waddr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata2;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] model [32];

  fb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got %0t required below 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference storage: what each register architecturally holds.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'h0;
    end else if (we === 1'b1 && waddr != 5'd0) begin
      model[waddr] <= wdata;
    end
  end

  // Architectural read value: zero in reset or at x0, pending write data when
  // the port targets the register being written, otherwise stored contents.
  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (reset !== 1'b1) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (we === 1'b1 && waddr == a) return wdata;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_rdata1", rdata1, expect_rd(raddr1));
      check("model_rdata2", rdata2, expect_rd(raddr2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2;
  endtask

  initial begin
    logic [4:0] a1, a2;
    reset = 1'b0;
    drive(1'b1, 5'd1, 32'hCAFE_F00D, 5'd1, 5'd1);
    #2;
    check("reset_bypass_r1", rdata1, 32'h0);
    check("reset_bypass_r2", rdata2, 32'h0);
    #10;
    we = 1'b0;
    #1;
    reset = 1'b1;
    cmp_en = 1'b1;
    #1;

    // All addresses read zero after reset on both ports.
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #0.1;
      check("post_reset_r1", rdata1, 32'h0);
      check("post_reset_r2", rdata2, 32'h0);
    end

    // Bypass during the write cycle, then stored value after the edge.
    step();
    drive(1'b1, 5'd8, 32'h0000_0004, 5'd8, 5'd8);
    #2;
    check("bypass_r1_reg8", rdata1, 32'h0000_0004);
    check("bypass_r2_reg8", rdata2, 32'h0000_0004);
    step();
    check("after_edge_reg8", rdata1, 32'h0000_0004);
    @(negedge clk);
    #1;
    we = 1'b0;
    #1;
    check("hold_reg8", rdata1, 32'h0000_0004);

    // Writes to x0 never land, nor bypass.
    step();
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd8);
    #2;
    check("x0_during_write", rdata1, 32'h0);
    step();
    we = 1'b0;
    #1;
    check("x0_after_write", rdata1, 32'h0);

    // Two registers, independent ports, swap addresses.
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd31, 32'h1234_5678, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd3, 32'hAAAA_AAAA, 5'd5, 5'd31);
    #1;
    check("r1_reg5", rdata1, 32'hDEAD_BEEF);
    check("r2_reg31", rdata2, 32'h1234_5678);
    raddr1 = 5'd31;
    raddr2 = 5'd5;
    #1;
    check("swap_r1_reg31", rdata1, 32'h1234_5678);
    check("swap_r2_reg5", rdata2, 32'hDEAD_BEEF);

    // we=0 leaves reg 3 alone.
    step();
    raddr1 = 5'd3;
    #1;
    check("no_write_reg3", rdata1, 32'h0);

    // X on we must not write or bypass.
    drive(1'bx, 5'd3, 32'h0BAD_0BAD, 5'd3, 5'd3);
    step();
    we = 1'b0;
    #1;
    check("x_we_reg3", rdata1, 32'h0);

    // Mid-cycle reset pulse discards contents, including a pending write.
    drive(1'b1, 5'd7, 32'h0000_0055, 5'd7, 5'd8);
    step();
    we = 1'b0;
    #1;
    check("reg7_written", rdata1, 32'h0000_0055);
    drive(1'b1, 5'd9, 32'h9999_9999, 5'd7, 5'd9);
    reset = 1'b0;
    #1;
    check("reset_clears_reg7", rdata1, 32'h0);
    check("reset_blocks_bypass", rdata2, 32'h0);
    step();
    we = 1'b0;
    reset = 1'b1;
    #1;
    check("reg7_stays_zero", rdata1, 32'h0);
    check("reg9_not_written", rdata2, 32'h0);
    raddr1 = 5'd8;
    #1;
    check("reg8_cleared", rdata1, 32'h0);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 600; n++) begin
      step();
      a1 = 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 99) < 3) ? 1'bx : 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31)),
            $urandom, a1, a2);
      if (reset == 1'b0) reset = 1'b1;
      else if ($urandom_range(0, 99) < 2) reset = 1'b0;
    end

    step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_regfile.md
FB_REGFILE -- requirements
Module: fb_regfile

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the register width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, giving the address width; register count = 2**ADDR_WIDTH (32 at default).
REQ-003 clk  input  1  single clock; all register writes occur on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 raddr1  input  ADDR_WIDTH  read port 1 address.
REQ-006 raddr2  input  ADDR_WIDTH  read port 2 address.
REQ-007 we  input  1  write enable, sampled at rising clk.
REQ-008 waddr  input  ADDR_WIDTH  write address.
REQ-009 wdata  input  DATA_WIDTH  write data.
REQ-010 rdata1  output  DATA_WIDTH  read port 1 data.
REQ-011 rdata2  output  DATA_WIDTH  read port 2 data.

Function
REQ-012 The block SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits, with RISC-V x0 semantics at address 0.
REQ-013 On a rising clk with reset high and we=1 and waddr!=0, register[waddr] SHALL take wdata.
REQ-014 Writes with we=0 or waddr=0 SHALL leave all registers unchanged.
REQ-015 Register 0 SHALL always read as 0, regardless of any write.
REQ-016 Reads SHALL be combinational (zero-cycle latency): rdataN = register[raddrN], updating within the same cycle an address changes.
REQ-017 Write-through bypass: when we=1, waddr!=0 and raddrN==waddr, rdataN SHALL equal wdata combinationally, before the edge commits the write.
REQ-018 Both read ports SHALL operate independently; both may address the same register, including the one being written, and each SHALL return the same, bypassed value.
REQ-019 Unknown or X values on we SHALL NOT corrupt any register in simulation; treat we as a write only when it is exactly 1.
REQ-020 A register written at edge N SHALL be visible on the read ports from just after edge N onward without bypass, persisting until its next write.

Reset
REQ-021 While reset=0, all registers SHALL be cleared to 0 asynchronously, with no clock required.
REQ-022 While reset=0, writes SHALL be ignored, and rdata1/rdata2 SHALL read 0 for every address, including when bypass conditions hold.
REQ-023 On reset deassertion (0->1), the first write SHALL take effect at the next rising clk.
REQ-024 Assertion of reset mid-operation SHALL discard all contents immediately, including any write in the same cycle.

Verification
REQ-025 Reset low, then high; read addresses 0..31 on both ports -> all return 0x00000000.
REQ-026 raddr1=8; at a rising edge drive we=1, waddr=8, wdata=0x00000004; deassert we at the following negedge -> rdata1=0x00000004 during the write cycle (bypass) and after the edge, holding after we=0.
REQ-027 we=1, waddr=0, wdata=0xFFFFFFFF, one clock; raddr1=0 -> rdata1=0x00000000, including during the write cycle.
REQ-028 Write 0xDEADBEEF to reg 5 and 0x12345678 to reg 31; set raddr1=5 and raddr2=31 -> rdata1=0xDEADBEEF and rdata2=0x12345678; swap the addresses -> the values swap in the same cycle.
REQ-029 we=0, waddr=3, wdata=0xAAAAAAAA, clock edge -> reg 3 remains at its prior value (0 after reset).
REQ-030 Write 0x55 to reg 7, then pulse reset low between clock edges -> rdata for reg 7 reads 0 immediately, and stays 0 after reset release until rewritten.
